clk_src_supervisor: RTL and testbench

//  Control side of the external/internal clock mux. It drives the mux's clk_int_select and

---
 rtl/clk_mux_pkg.sv | 12 +
 rtl/clk_status_sync.sv | 24 ++
 rtl/clk_src_supervisor.sv | 146 ++++++++++++++
 tb/tb_clk_src_supervisor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mux_pkg.sv
// Shared types and helpers for the clock source supervisor.
package clk_mux_pkg;

  typedef enum logic [1:0] {S_RST, S_LOCK, S_RUN} sup_state_t;
  typedef enum logic {SRC_INT, SRC_EXT} clk_src_t;

  // Bits needed to count 0..n-1, at least one bit so n=1 still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n >= 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_status_sync.sv
// Multi-flop synchronizer for a single asynchronous status bit.
module clk_status_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic async_i,
  output logic sync_o
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

  // Shift the async bit through the chain; the last stage is the safe copy.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clk_src_supervisor.sv
// Qualifies the external clock, drives the mux select and MMCM reset, and reports status.
module clk_src_supervisor
  import clk_mux_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned QUAL_CYCLES  = 4096,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ext_active_a,
  input  logic             locked_a,
  input  logic             force_int,
  input  logic             auto_en,
  output logic             clk_int_select,
  output logic             mmcm_nrst,
  output logic             clk_ready,
  output logic             on_ext,
  output logic             lock_fail,
  output logic [CNT_W-1:0] switch_count
);

  localparam int unsigned QUAL_W = cnt_width(QUAL_CYCLES);
  localparam int unsigned TMR_W  = cnt_width(LOCK_TIMEOUT);
  localparam int unsigned RST_W  = cnt_width(RST_CYCLES);

  localparam logic [QUAL_W-1:0] QUAL_MAX = QUAL_W'(QUAL_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_MAX  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [RST_W-1:0]  RST_MAX  = RST_W'(RST_CYCLES - 1);

  logic ext_s;
  logic locked_s;

  clk_status_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ext_sync (
    .clk     (clk),
    .nrst    (nrst),
    .async_i (ext_active_a),
    .sync_o  (ext_s)
  );

  clk_status_sync #(.SYNC_STAGES(SYNC_STAGES)) u_locked_sync (
    .clk     (clk),
    .nrst    (nrst),
    .async_i (locked_a),
    .sync_o  (locked_s)
  );

  sup_state_t        state_q, state_d;
  clk_src_t          target_q, target_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [QUAL_W-1:0] qual_q, qual_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic              lock_fail_d;
  logic              bump;  // one source change this cycle

  // Next-state decision; qual defaults to clear so it only survives while qualifying in S_RUN.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    timer_d     = timer_q;
    qual_d      = '0;
    rst_cnt_d   = rst_cnt_q;
    lock_fail_d = lock_fail;
    bump        = 1'b0;
    unique case (state_q)
      S_RST: begin
        if (rst_cnt_q == RST_MAX) begin
          state_d = S_LOCK;
          timer_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      S_LOCK: begin
        if (locked_s) begin
          state_d = S_RUN;
        end else if (timer_q == TMR_MAX) begin
          lock_fail_d = 1'b1;
          target_d    = SRC_INT;
          state_d     = S_RST;
          rst_cnt_d   = '0;
          bump        = (target_q == SRC_EXT);
        end else if (target_q == SRC_EXT && !ext_s) begin
          target_d = SRC_INT;
          bump     = 1'b1;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RUN: begin
        timer_d = '0;  // any exit from S_RUN lands in S_LOCK with a fresh timer
        if (target_q == SRC_EXT && (!ext_s || force_int || !auto_en)) begin
          target_d = SRC_INT;
          bump     = 1'b1;
          state_d  = S_LOCK;
        end else if (!locked_s) begin
          state_d = S_LOCK;
        end else if (target_q == SRC_INT && ext_s && auto_en && !force_int) begin
          if (qual_q == QUAL_MAX) begin
            target_d = SRC_EXT;
            bump     = 1'b1;
            state_d  = S_LOCK;
          end else begin
            qual_d = qual_q + QUAL_W'(1);
          end
        end
      end
      default: state_d = S_RST;
    endcase
  end

  // State and registered outputs; outputs follow the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q        <= S_RST;
      target_q       <= SRC_INT;
      timer_q        <= '0;
      qual_q         <= '0;
      rst_cnt_q      <= '0;
      clk_int_select <= 1'b1;
      mmcm_nrst      <= 1'b0;
      clk_ready      <= 1'b0;
      on_ext         <= 1'b0;
      lock_fail      <= 1'b0;
      switch_count   <= '0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      timer_q        <= timer_d;
      qual_q         <= qual_d;
      rst_cnt_q      <= rst_cnt_d;
      clk_int_select <= (target_d == SRC_INT);
      mmcm_nrst      <= (state_d != S_RST);
      clk_ready      <= (state_d == S_RUN);
      on_ext         <= (state_d == S_RUN) && (target_d == SRC_EXT);
      lock_fail      <= lock_fail_d;
      if (bump && (switch_count != '1)) begin
        switch_count <= switch_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clk_src_supervisor.sv
// Directed bench for clk_src_supervisor with short timing parameters.
module tb_clk_src_supervisor;

  logic       clk = 1'b0;
  logic       nrst;
  logic       ext_active_a;
  logic       locked_a;
  logic       force_int;
  logic       auto_en;
  logic       clk_int_select;
  logic       mmcm_nrst;
  logic       clk_ready;
  logic       on_ext;
  logic       lock_fail;
  logic [3:0] switch_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_cnt;

  // Narrow counter so saturation is reachable in a short run.
  clk_src_supervisor #(
    .SYNC_STAGES  (2),
    .QUAL_CYCLES  (8),
    .LOCK_TIMEOUT (32),
    .RST_CYCLES   (4),
    .CNT_W        (4)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .ext_active_a   (ext_active_a),
    .locked_a       (locked_a),
    .force_int      (force_int),
    .auto_en        (auto_en),
    .clk_int_select (clk_int_select),
    .mmcm_nrst      (mmcm_nrst),
    .clk_ready      (clk_ready),
    .on_ext         (on_ext),
    .lock_fail      (lock_fail),
    .switch_count   (switch_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  initial begin
    nrst = 1'b0; ext_active_a = 1'b0; locked_a = 1'b0; force_int = 1'b0; auto_en = 1'b0;

    // 1. reset values, release pulse length, first lock
    step(3);
    check_eq("rst_select", clk_int_select, 1);
    check_eq("rst_mmcm", mmcm_nrst, 0);
    check_eq("rst_ready", clk_ready, 0);
    check_eq("rst_on_ext", on_ext, 0);
    check_eq("rst_lock_fail", lock_fail, 0);
    check_eq("rst_count", switch_count, 0);
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_eq("rel_mmcm_low", mmcm_nrst, 0);
    end
    step(1);
    check_eq("rel_mmcm_high", mmcm_nrst, 1);
    check_eq("rel_ready_low", clk_ready, 0);
    locked_a = 1'b1;
    step(2);
    check_eq("lock_sync_wait", clk_ready, 0);
    step(1);
    check_eq("lock_ready", clk_ready, 1);
    check_eq("lock_select_int", clk_int_select, 1);

    // 2. qualification: 7 synced cycles is short, 8 switches
    auto_en = 1'b1;
    ext_active_a = 1'b1;
    step(7);
    ext_active_a = 1'b0;
    step(5);
    check_eq("qual_short_select", clk_int_select, 1);
    check_eq("qual_short_count", switch_count, 0);
    check_eq("qual_short_ready", clk_ready, 1);
    ext_active_a = 1'b1;
    step(9);
    check_eq("qual_pre_select", clk_int_select, 1);
    step(1);
    check_eq("qual_select", clk_int_select, 0);
    check_eq("qual_count", switch_count, 1);
    check_eq("qual_ready_drop", clk_ready, 0);
    check_eq("qual_on_ext_lock", on_ext, 0);
    step(1);
    check_eq("qual_ready", clk_ready, 1);
    check_eq("qual_on_ext", on_ext, 1);
    check_eq("qual_mmcm", mmcm_nrst, 1);

    // 3. external loss while running on it
    ext_active_a = 1'b0;
    step(2);
    check_eq("loss_pre_select", clk_int_select, 0);
    check_eq("loss_pre_on_ext", on_ext, 1);
    step(1);
    check_eq("loss_select", clk_int_select, 1);
    check_eq("loss_count", switch_count, 2);
    check_eq("loss_on_ext", on_ext, 0);
    check_eq("loss_mmcm", mmcm_nrst, 1);
    step(1);
    check_eq("loss_ready", clk_ready, 1);
    check_eq("loss_mmcm2", mmcm_nrst, 1);

    // 4. lock timeout on internal source
    locked_a = 1'b0;
    step(3);
    check_eq("to_ready_drop", clk_ready, 0);
    check_eq("to_mmcm_lock", mmcm_nrst, 1);
    step(31);
    check_eq("to_pre_fail", lock_fail, 0);
    check_eq("to_pre_mmcm", mmcm_nrst, 1);
    step(1);
    check_eq("to_fail", lock_fail, 1);
    check_eq("to_mmcm_low", mmcm_nrst, 0);
    check_eq("to_select", clk_int_select, 1);
    check_eq("to_count", switch_count, 2);
    step(3);
    check_eq("to_mmcm_low4", mmcm_nrst, 0);
    step(1);
    check_eq("to_mmcm_high", mmcm_nrst, 1);
    check_eq("to_fail_sticky", lock_fail, 1);
    locked_a = 1'b1;
    step(3);
    check_eq("to_relock_ready", clk_ready, 1);
    check_eq("to_fail_sticky2", lock_fail, 1);

    // 5a. simultaneous ext and lock loss counts once
    ext_active_a = 1'b1;
    step(10);
    check_eq("sim_select_ext", clk_int_select, 0);
    check_eq("sim_count_ext", switch_count, 3);
    step(1);
    check_eq("sim_on_ext", on_ext, 1);
    ext_active_a = 1'b0;
    locked_a = 1'b0;
    step(3);
    check_eq("sim_select", clk_int_select, 1);
    check_eq("sim_count", switch_count, 4);
    check_eq("sim_ready", clk_ready, 0);
    step(2);
    check_eq("sim_count_hold", switch_count, 4);
    check_eq("sim_ready_hold", clk_ready, 0);
    locked_a = 1'b1;
    step(3);
    check_eq("sim_relock", clk_ready, 1);
    check_eq("sim_count_final", switch_count, 4);

    // 5b. force_int falls back on the next edge
    ext_active_a = 1'b1;
    step(10);
    check_eq("frc_count_ext", switch_count, 5);
    step(1);
    check_eq("frc_on_ext", on_ext, 1);
    force_int = 1'b1;
    step(1);
    check_eq("frc_select", clk_int_select, 1);
    check_eq("frc_count", switch_count, 6);
    check_eq("frc_on_ext_off", on_ext, 0);
    step(1);
    check_eq("frc_ready", clk_ready, 1);

    // 5c. toggle force_int until the counter saturates
    exp_cnt = 4'd6;
    for (int i = 0; i < 5; i++) begin
      force_int = 1'b0;
      step(8);
      exp_cnt = sat_inc(exp_cnt);
      check_eq("sat_to_ext", clk_int_select, 0);
      check_eq("sat_count_up", switch_count, exp_cnt);
      step(1);
      force_int = 1'b1;
      step(1);
      exp_cnt = sat_inc(exp_cnt);
      check_eq("sat_to_int", clk_int_select, 1);
      check_eq("sat_count_dn", switch_count, exp_cnt);
      step(1);
    end
    check_eq("sat_final", switch_count, 4'hF);

    // 6. reset mid-timeout, then timer restarts from zero
    locked_a = 1'b0;
    step(3);
    check_eq("mid_ready_drop", clk_ready, 0);
    step(10);
    nrst = 1'b0;
    step(1);
    check_eq("mid_select", clk_int_select, 1);
    check_eq("mid_mmcm", mmcm_nrst, 0);
    check_eq("mid_ready", clk_ready, 0);
    check_eq("mid_on_ext", on_ext, 0);
    check_eq("mid_lock_fail", lock_fail, 0);
    check_eq("mid_count", switch_count, 0);
    nrst = 1'b1;
    step(35);
    check_eq("mid_pre_fail", lock_fail, 0);
    check_eq("mid_pre_mmcm", mmcm_nrst, 1);
    step(1);
    check_eq("mid_fail", lock_fail, 1);
    check_eq("mid_fail_mmcm", mmcm_nrst, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
